// File: rtl/mem_arbiter_if.sv
// Bus bundle between the request logic, the RAM model and mem_arbiter.
// The arbiter takes the slave modport. The request logic and RAM side take the master modport.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Handshake: a requester raises iREN or dREN/dWEN and holds it, with its operands stable,
    // until its wait is 0. The transfer completes in that cycle. Load data is valid only then.
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] iload;
    logic          iwait;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic [DW-1:0] dload;
    logic          dwait;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic [1:0]    ramstate;
    logic          err;
    logic          busy;
    logic [1:0]    dbgState;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err, busy, dbgState
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err, busy, dbgState
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction fetch and data access. It has a serve-timeout watchdog.
// Define ARB_RR_EN for round-robin arbitration under contention. Without it, data requests have fixed priority.
module mem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IFETCH = 2'd1;
    localparam logic [1:0] DREAD  = 2'd2;
    localparam logic [1:0] DWRITE = 2'd3;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    nextState;
    logic [1:0]    grantState;
    logic [CW-1:0] timeoutCnt;
    logic [AW-1:0] ramaddrQ;
    logic [DW-1:0] ramstoreQ;
    logic          serving;
    logic          reqHeld;
    logic          accessHit;
    logic          ramFault;
    logic          pickData;
`ifdef ARB_RR_EN
    logic          lastData;
`endif

    always_comb begin
        serving = (state != IDLE);
        case (state)
            IFETCH:  reqHeld = bus.iREN;
            DREAD:   reqHeld = bus.dREN;
            DWRITE:  reqHeld = bus.dWEN;
            default: reqHeld = 1'b0;
        endcase
        accessHit = serving && (bus.ramstate == RAM_ACCESS);
        // A dropped request counts as an abort, so it never raises err.
        ramFault  = serving && !accessHit && reqHeld &&
                    ((bus.ramstate == RAM_ERROR) || (timeoutCnt == CNT_MAX));
`ifdef ARB_RR_EN
        pickData = (bus.dREN || bus.dWEN) && (!bus.iREN || !lastData);
`else
        pickData = bus.dREN || bus.dWEN;
`endif
        if (pickData)
            grantState = bus.dWEN ? DWRITE : DREAD;
        else if (bus.iREN)
            grantState = IFETCH;
        else
            grantState = IDLE;

        if (!serving)
            nextState = grantState;
        else if (accessHit || !reqHeld || ramFault)
            nextState = IDLE;
        else
            nextState = state;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            timeoutCnt <= '0;
            ramaddrQ   <= '0;
            ramstoreQ  <= '0;
`ifdef ARB_RR_EN
            lastData   <= 1'b0;
`endif
        end else begin
            state <= nextState;
            if (!serving) begin
                if (grantState != IDLE) begin
                    ramaddrQ   <= pickData ? bus.daddr : bus.iaddr;
                    if (grantState == DWRITE)
                        ramstoreQ <= bus.dstore;
                    timeoutCnt <= '0;
`ifdef ARB_RR_EN
                    lastData   <= pickData;
`endif
                end
            end else if (!accessHit && (timeoutCnt != CNT_MAX)) begin
                timeoutCnt <= timeoutCnt + 1'b1;
            end
        end
    end

    assign bus.ramREN   = (state == IFETCH) || (state == DREAD);
    assign bus.ramWEN   = (state == DWRITE);
    assign bus.ramaddr  = ramaddrQ;
    assign bus.ramstore = ramstoreQ;
    assign bus.iwait    = !((state == IFETCH) && accessHit);
    assign bus.dwait    = !(((state == DREAD) || (state == DWRITE)) && accessHit);
    assign bus.iload    = ((state == IFETCH) && accessHit) ? bus.ramload : '0;
    assign bus.dload    = ((state == DREAD) && accessHit) ? bus.ramload : '0;
    assign bus.err      = ramFault;
    assign bus.busy     = serving;
    assign bus.dbgState = state;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port RAM arbiter between the instruction-fetch requester and the data requester (the data requester is the request unit's gated dmemREN/dmemWEN path).
- Grants one requester at a time, holds the captured address and store data for the RAM, and returns load data with a wait/ready handshake.
- Sits between the datapath request logic and the RAM model. Includes a timeout watchdog and RAM-error handling.

Parameters:
TIMEOUT, 16, max cycles in a serve state without ramstate==ACCESS before abort (>=2)
AW, 32, address width
DW, 32, data word width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
iREN  in  1  instruction read request
iaddr  in  AW  instruction address
iload  out  DW  instruction read data
iwait  out  1  1 = instruction request not complete
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  AW  data address
dstore  in  DW  data write value
dload  out  DW  data read data
dwait  out  1  1 = data request not complete
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  AW  RAM address
ramstore  out  DW  RAM write data
ramload  in  DW  RAM read data
ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
err  out  1  one-cycle pulse on RAM ERROR or timeout
busy  out  1  1 when state != IDLE

Behaviour:
- States: IDLE, IFETCH, DREAD, DWRITE. Registered state; asynchronous reset to IDLE.
- Reset values: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0, err=0, busy=0, timeout counter=0.
- IDLE selection, evaluated at each rising edge:
  - dWEN -> DWRITE.
  - else dREN -> DREAD.
  - else iREN -> IFETCH.
  - Data has fixed priority over instruction. dREN and dWEN both high is treated as a write.
- On the grant edge: capture the selected address into ramaddr. For DWRITE also capture dstore into ramstore. Clear the counter.
- Serve states: ramREN=1 in IFETCH/DREAD; ramWEN=1 in DWRITE. Enables are decoded from registered state, so the first enable appears the cycle after the request is seen in IDLE.
- Completion: in a serve state with ramstate==ACCESS:
  - The granted wait goes 0 combinationally in that cycle.
  - iload/dload = ramload in that cycle for reads.
  - Next state is IDLE.
- Outside a completing cycle, iload/dload are 0 and the non-granted wait stays 1.
- Requester protocol: hold the request and operands stable until its wait is 0. The arbiter uses only the captured address and data.
- Abort: the granted request deasserts before ACCESS -> IDLE next edge, no err, enables drop.
- ramstate==ERROR in a serve state -> err=1 for one cycle, wait stays 1, IDLE next edge. The requester retries.
- Timeout: the counter increments each serve cycle without ACCESS. When it reaches TIMEOUT-1 -> err pulse, IDLE next edge. The counter saturates and is never reused across grants.
- Throughput: minimum 2 cycles per access (grant plus ACCESS), plus RAM latency. There is always one IDLE cycle between transactions.
- RST asserted mid-transaction: immediate return to reset values. No partial write completes beyond what RAM already sampled.

Optional Feature:
- ARB_RR_EN:
  - Defined: a 1-bit last-served register (reset = instruction) makes arbitration round-robin when both dREN/dWEN and iREN are pending in IDLE; the requester not served last wins. A single pending requester is granted as normal.
  - Undefined: fixed data priority as above; the last-served register is absent.

Test Plan:
- Reset: RST=1 mid-DWRITE with ramstate=BUSY -> next sample ramWEN=0, dwait=1, iwait=1, busy=0, err=0.
- Fetch: iREN=1, iaddr=0x40, RAM ACCESS on 2nd serve cycle with ramload=0xDEADBEEF -> ramREN high 2 cycles, ramaddr=0x40, iwait=0 and iload=0xDEADBEEF in ACCESS cycle only, busy=0 next cycle.
- Contention:
  - Setup: iREN=1 and dWEN=1 (daddr=0x80, dstore=0x1234) pending together.
  - Without ARB_RR_EN: DWRITE first with ramstore=0x1234, then IFETCH after one IDLE.
  - With ARB_RR_EN: first grant is data (last-served resets to instruction); a repeated contention is then granted to instruction.
- Error: DREAD with ramstate=ERROR on first serve cycle -> err=1 for exactly 1 cycle, dwait=1, returns IDLE and re-grants DREAD on the next edge since dREN is held.
- Timeout: TIMEOUT=4, ramstate stuck BUSY -> err pulse after 4 serve cycles, busy=0 afterwards.
- Abort: iREN dropped after 1 serve cycle -> ramREN=0 next cycle, no err, iwait=1.
